// File: rtl/result_uart_tx_pkg.sv
// Shared types and ASCII constants for the game-result UART reporter.
package result_uart_tx_pkg;

  localparam logic [7:0] ASCII_W     = 8'h57;
  localparam logic [7:0] ASCII_L     = 8'h4C;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int unsigned REPORT_LEN = 10;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_tx_state_t;

  // Non-decimal nibbles are shown as '?' rather than garbage glyphs.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
    return (d > 4'd9) ? ASCII_QMARK : (ASCII_ZERO + {4'h0, d});
  endfunction

endpackage

// File: rtl/result_uart_tx_byte.sv
// 8N1 serialiser for one byte; accepting in the last stop-bit cycle gives gapless frames.
module uart_tx_byte
  import result_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       res_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       frame_done_o
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  uart_tx_state_t state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           bit_end;

  assign bit_end      = (timer_q == LAST);
  assign ready_o      = (state_q == StIdle) || ((state_q == StStop) && bit_end);
  assign frame_done_o = (state_q == StStop) && bit_end;
  assign busy_o       = (state_q != StIdle);
  assign tx_o         = tx_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q != StIdle) timer_d = bit_end ? '0 : timer_q + TW'(1);
    unique case (state_q)
      StIdle: ;
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      StStop: if (bit_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (valid_i && ready_o) begin
      state_d = StStart;
      timer_d = '0;
      bit_d   = '0;
      shift_d = data_i;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state_q <= StIdle;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Snapshots a game result on a strobe and sends "W|L sss.ff\r\n" over UART.
module result_uart_tx
  import result_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_TICKS_PER_SEC = 50_000_000,
  parameter int unsigned BAUD_RATE         = 115_200
) (
  input  logic        clk_i,
  input  logic        res_i,
  input  logic        report_stb_i,
  input  logic        win_i,
  input  logic [11:0] sec_bcd_i,
  input  logic [7:0]  frac_bcd_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_stb_o,
  output logic        drop_stb_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_TICKS_PER_SEC / BAUD_RATE;
  localparam logic [3:0]  LAST_IDX     = 4'(REPORT_LEN);

  logic        active_q;
  logic [3:0]  idx_q;
  logic        snap_win_q;
  logic [11:0] snap_sec_q;
  logic [7:0]  snap_frac_q;
  logic        done_q, drop_q;
  logic [7:0]  byte_data;
  logic        byte_valid, byte_ready, frame_done, accept, record_end, capture;

  assign byte_valid = active_q && (idx_q != LAST_IDX);
  assign accept     = byte_valid && byte_ready;
  assign record_end = active_q && (idx_q == LAST_IDX) && frame_done;
  assign capture    = report_stb_i && !active_q;
  assign done_stb_o = done_q;
  assign drop_stb_o = drop_q;

  always_comb begin
    byte_data = ASCII_LF;
    unique case (idx_q)
      4'd0:    byte_data = snap_win_q ? ASCII_W : ASCII_L;
      4'd1:    byte_data = ASCII_SPACE;
      4'd2:    byte_data = bcd_to_ascii(snap_sec_q[11:8]);
      4'd3:    byte_data = bcd_to_ascii(snap_sec_q[7:4]);
      4'd4:    byte_data = bcd_to_ascii(snap_sec_q[3:0]);
      4'd5:    byte_data = ASCII_DOT;
      4'd6:    byte_data = bcd_to_ascii(snap_frac_q[7:4]);
      4'd7:    byte_data = bcd_to_ascii(snap_frac_q[3:0]);
      4'd8:    byte_data = ASCII_CR;
      default: byte_data = ASCII_LF;
    endcase
  end

  // active_q covers the capture cycle too, so a strobe one cycle later is a drop.
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      active_q    <= 1'b0;
      idx_q       <= '0;
      snap_win_q  <= 1'b0;
      snap_sec_q  <= '0;
      snap_frac_q <= '0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      done_q <= record_end;
      drop_q <= report_stb_i && active_q;
      if (capture) begin
        active_q    <= 1'b1;
        idx_q       <= '0;
        snap_win_q  <= win_i;
        snap_sec_q  <= sec_bcd_i;
        snap_frac_q <= frac_bcd_i;
      end else begin
        if (accept) idx_q <= idx_q + 4'd1;
        if (record_end) active_q <= 1'b0;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk_i       (clk_i),
    .res_i       (res_i),
    .valid_i     (byte_valid),
    .data_i      (byte_data),
    .ready_o     (byte_ready),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .frame_done_o(frame_done)
  );

endmodule
